// File: rtl/mac_row_sequencer_if.sv
// Operand-RAM and multiply-add stage connections of the row sequencer.
// master = sequencer side, slave = RAM / multiply-add side.
interface mac_row_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic [DATA_WIDTH-1:0] c_rdata;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] ma_x;
    logic [DATA_WIDTH-1:0] ma_y;
    logic [DATA_WIDTH-1:0] ma_z;
    logic [DATA_WIDTH-1:0] ma_cin;
    logic [DATA_WIDTH-1:0] ma_s;
    logic [DATA_WIDTH-1:0] ma_cout;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output ma_x, ma_y, ma_z, ma_cin,
        input  a_rdata, c_rdata, ma_s, ma_cout
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  ma_x, ma_y, ma_z, ma_cin,
        output a_rdata, c_rdata, ma_s, ma_cout
    );
endinterface

// File: rtl/mac_row_sequencer.sv
// One schoolbook-multiply row pass: C[0..N-1] += A[0..N-1] * b, streaming one
// word per cycle through an external combinational multiply-add stage.
module mac_row_sequencer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_WORDS  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  zero_c,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] carry_out,
    mac_row_sequencer_if.master   bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [ADDR_WIDTH-1:0] w_index_nxt;
    logic [DATA_WIDTH-1:0] r_carry;
    logic [DATA_WIDTH-1:0] w_carry_nxt;
    logic [DATA_WIDTH-1:0] r_carry_out;
    logic [DATA_WIDTH-1:0] w_carry_out_nxt;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] w_b_nxt;
    logic                  r_zero;
    logic                  w_zero_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_index     <= '0;
            r_carry     <= '0;
            r_carry_out <= '0;
            r_b         <= '0;
            r_zero      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_index     <= w_index_nxt;
            r_carry     <= w_carry_nxt;
            r_carry_out <= w_carry_out_nxt;
            r_b         <= w_b_nxt;
            r_zero      <= w_zero_nxt;
        end
    end

    // The last RUN cycle also loads carry_out so it is already valid while done is high.
    always_comb begin
        w_state_nxt     = r_state;
        w_index_nxt     = r_index;
        w_carry_nxt     = r_carry;
        w_carry_out_nxt = r_carry_out;
        w_b_nxt         = r_b;
        w_zero_nxt      = r_zero;
        busy            = 1'b1;
        done            = 1'b0;
        bus.rd_en       = 1'b0;
        bus.rd_addr     = '0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.ma_x        = '0;
        bus.ma_y        = '0;
        bus.ma_z        = '0;
        bus.ma_cin      = '0;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_b_nxt         = b;
                    w_zero_nxt      = zero_c;
                    w_carry_nxt     = '0;
                    w_carry_out_nxt = '0;
                    w_index_nxt     = '0;
                    w_state_nxt     = ST_PRIME;
                end
            end
            ST_PRIME: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = '0;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                bus.ma_x    = bus.a_rdata;
                bus.ma_y    = r_b;
                bus.ma_z    = r_zero ? DATA_WIDTH'(0) : bus.c_rdata;
                bus.ma_cin  = r_carry;
                bus.wr_en   = 1'b1;
                bus.wr_addr = r_index;
                bus.wr_data = bus.ma_s;
                w_carry_nxt = bus.ma_cout;
                if (r_index != LAST_IDX) begin
                    bus.rd_en   = 1'b1;
                    bus.rd_addr = r_index + ADDR_WIDTH'(1);
                    w_index_nxt = r_index + ADDR_WIDTH'(1);
                end else begin
                    w_carry_out_nxt = bus.ma_cout;
                    w_state_nxt     = ST_DONE;
                end
            end
            ST_DONE: begin
                done            = 1'b1;
                w_carry_out_nxt = r_carry;
                w_state_nxt     = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign carry_out = r_carry_out;
endmodule
